// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_PRESENT,
        OUT_WAIT
    } uart_txq_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage for the TX FIFO: one synchronous write port, one combinational read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [UART_BYTE_W-1:0]     wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [UART_BYTE_W-1:0]     rdata_o
);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx; holds each head byte on tx_valid/tx_data until uart_tx drops tx_ready.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic                     tx_valid,
    output logic [UART_BYTE_W-1:0]   tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                     overflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    uart_txq_state_t        state_q;
    logic                   tx_valid_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic [UART_BYTE_W-1:0] head;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (level == '0);
    assign wr_ready = !full;

    // Pop happens when uart_tx shows it has latched the presented byte; flush overrides both sides.
    assign push = wr_valid && !full && !flush;
    assign pop  = (state_q == OUT_PRESENT) && !tx_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head)
    );

    // New bytes are only presented while tx_ready is high, so tx_valid never rises into a busy uart_tx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OUT_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                OUT_IDLE: begin
                    if (!flush && !empty && tx_ready) begin
                        tx_data_q  <= head;
                        tx_valid_q <= 1'b1;
                        state_q    <= OUT_PRESENT;
                    end
                end
                OUT_PRESENT: begin
                    if (flush || !tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= OUT_WAIT;
                    end
                end
                OUT_WAIT: begin
                    if (tx_ready) begin
                        if (!flush && !empty) begin
                            tx_data_q  <= head;
                            tx_valid_q <= 1'b1;
                            state_q    <= OUT_PRESENT;
                        end else begin
                            state_q <= OUT_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= OUT_IDLE;
                end
            endcase
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (wr_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule
